// File: rtl/i2c_master_burst.sv
// Register-addressed I2C burst master: write (S, addr+W, reg, data.., P) and
// read (S, addr+W, reg, Sr, addr+R, data.., P) with an open-drain style SDA enable.
module i2c_master_burst #(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             dev_addr,
    input  logic [7:0]             inner_addr,
    input  logic [LEN_W-1:0]       len,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   scl,
    output logic                   sda_oe,
    input  logic                   sda_i
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, RSTART, ADDR_R,
        ACK_AR, WDATA, ACK_D, RDATA, MACK, STOP, FIN
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [1:0]             ph_q, ph_d;
    logic [2:0]             bit_q, bit_d;
    logic [LEN_W-1:0]       byte_q, byte_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             rx_q, rx_d;
    logic                   samp_q, samp_d;
    logic                   rw_q, rw_d;
    logic [6:0]             dev_q, dev_d;
    logic [7:0]             reg_q, reg_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [8*MAX_BYTES-1:0] wr_q, wr_d;
    logic [8*MAX_BYTES-1:0] rd_q, rd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   scl_q, scl_d;
    logic                   oe_q, oe_d;

    logic                   tick;
    logic                   last_byte;
    logic [MAX_BYTES-1:0]   rd_sel;

    // One-hot destination slot for the byte currently being received.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_rd_sel
            assign rd_sel[gi] = (byte_q == LEN_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        samp_d    = samp_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        len_d     = len_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tick      = (div_q == DIV_W'(CLK_DIV - 1));
        last_byte = (byte_q == len_q - LEN_W'(1));

        if (state_q == IDLE || state_q == FIN) begin
            state_d = IDLE;
            div_d   = '0;
            ph_d    = 2'd0;
            bit_d   = 3'd0;
            byte_d  = '0;
            busy_d  = 1'b0;
            if (start) begin
                rw_d  = rw;
                dev_d = dev_addr;
                reg_d = inner_addr;
                len_d = len;
                wr_d  = wr_data;
                rd_d  = '0;
                err_d = 1'b0;
                if (len == '0 || len > LEN_W'(MAX_BYTES)) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                ph_d = ph_q + 2'd1;
                if (ph_q == 2'd2) begin
                    samp_d = sda_i;
                    rx_d   = {rx_q[6:0], sda_i};
                end
                if (ph_q == 2'd3) begin
                    case (state_q)
                        START: begin
                            state_d = ADDR_W;
                            tx_d    = {dev_q, 1'b0};
                        end
                        ADDR_W, REG, ADDR_R, WDATA, RDATA: begin
                            tx_d  = {tx_q[6:0], 1'b0};
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                case (state_q)
                                    ADDR_W:  state_d = ACK_A;
                                    REG:     state_d = ACK_R;
                                    ADDR_R:  state_d = ACK_AR;
                                    WDATA:   state_d = ACK_D;
                                    default: state_d = MACK;
                                endcase
                                if (state_q == RDATA) begin
                                    for (int i = 0; i < MAX_BYTES; i++) begin
                                        if (rd_sel[i]) rd_d[8*i +: 8] = rx_q;
                                    end
                                end
                            end
                        end
                        ACK_A: begin
                            if (samp_q) begin
                                err_d   = 1'b1;
                                state_d = STOP;
                            end else begin
                                state_d = REG;
                                tx_d    = reg_q;
                            end
                        end
                        ACK_R: begin
                            if (samp_q) begin
                                err_d   = 1'b1;
                                state_d = STOP;
                            end else if (rw_q) begin
                                state_d = RSTART;
                            end else begin
                                state_d = WDATA;
                                tx_d    = wr_q[7:0];
                                wr_d    = wr_q >> 8;
                                byte_d  = '0;
                            end
                        end
                        RSTART: begin
                            state_d = ADDR_R;
                            tx_d    = {dev_q, 1'b1};
                        end
                        ACK_AR: begin
                            if (samp_q) begin
                                err_d   = 1'b1;
                                state_d = STOP;
                            end else begin
                                state_d = RDATA;
                                byte_d  = '0;
                            end
                        end
                        ACK_D: begin
                            if (samp_q) begin
                                err_d   = 1'b1;
                                state_d = STOP;
                            end else if (last_byte) begin
                                state_d = STOP;
                            end else begin
                                state_d = WDATA;
                                tx_d    = wr_q[7:0];
                                wr_d    = wr_q >> 8;
                                byte_d  = byte_q + LEN_W'(1);
                            end
                        end
                        MACK: begin
                            if (last_byte) begin
                                state_d = STOP;
                            end else begin
                                state_d = RDATA;
                                byte_d  = byte_q + LEN_W'(1);
                            end
                        end
                        STOP: begin
                            state_d = FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end

        // Pin levels are a pure function of the upcoming state/phase so they register cleanly.
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            START: begin
                scl_d = 1'b1;
                oe_d  = ph_d[1];
            end
            RSTART: begin
                scl_d = (ph_d != 2'd0);
                oe_d  = ph_d[1];
            end
            STOP: begin
                scl_d = (ph_d != 2'd0);
                oe_d  = ~ph_d[1];
            end
            ADDR_W, REG, ADDR_R, WDATA: begin
                scl_d = ph_d[1];
                oe_d  = ~tx_d[7];
            end
            ACK_A, ACK_R, ACK_AR, ACK_D, RDATA: begin
                scl_d = ph_d[1];
                oe_d  = 1'b0;
            end
            MACK: begin
                scl_d = ph_d[1];
                oe_d  = (byte_d != len_d - LEN_W'(1));
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            ph_q    <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= '0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            samp_q  <= 1'b0;
            rw_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            samp_q  <= samp_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
        end
    end

    assign rd_data = rd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign scl     = scl_q;
    assign sda_oe  = oe_q;

endmodule
